serial_add_sequencer: RTL

//   Sequences one shared, purely combinational half-adder to perform WIDTH-bit

---
 rtl/serial_add_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// Control sequencer that performs a WIDTH-bit add with carry-in, LSB first,
// by time-sharing one external combinational half-adder for two cycles per bit.
module serial_add_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy,
    output logic             ha_a,
    output logic             ha_b,
    input  logic             ha_sum,
    input  logic             ha_carry
);

    localparam int unsigned IDX_W  = $clog2(WIDTH);
    localparam int unsigned PART_W = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic                carry_q, carry_d;
    logic                c1_q, c1_d;
    logic [PART_W-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]    res_sum_d;
    logic                res_cout_d;
    logic                req_ready_d;
    logic                res_valid_d;
    logic                busy_d;
    logic                ha_a_d;
    logic                ha_b_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-register decode. The registered ha_a in P1 is the
    // P0 partial sum, so it doubles as the s1 register.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        carry_d    = carry_q;
        c1_d       = c1_q;
        sum_d      = sum_q;
        res_sum_d  = res_sum;
        res_cout_d = res_cout;
        ha_a_d     = 1'b0;
        ha_b_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    opa_d   = op_a;
                    opb_d   = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    ha_a_d  = op_a[0];
                    ha_b_d  = op_b[0];
                    state_d = P0;
                end
            end
            P0: begin
                c1_d    = ha_carry;
                ha_a_d  = ha_sum;
                ha_b_d  = carry_q;
                state_d = P1;
            end
            P1: begin
                sum_d   = PART_W'({ha_sum, sum_q} >> 1);
                carry_d = c1_q | ha_carry;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                if (idx_q == LAST_IDX) begin
                    res_sum_d  = {ha_sum, sum_q};
                    res_cout_d = c1_q | ha_carry;
                    state_d    = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    ha_a_d  = opa_q[1];
                    ha_b_d  = opb_q[1];
                    state_d = P0;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            carry_q   <= 1'b0;
            c1_q      <= 1'b0;
            sum_q     <= '0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            ha_a      <= 1'b0;
            ha_b      <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            carry_q   <= carry_d;
            c1_q      <= c1_d;
            sum_q     <= sum_d;
            res_sum   <= res_sum_d;
            res_cout  <= res_cout_d;
            req_ready <= req_ready_d;
            res_valid <= res_valid_d;
            busy      <= busy_d;
            ha_a      <= ha_a_d;
            ha_b      <= ha_b_d;
        end
    end

endmodule
